// File: rtl/aurora_tx_arbiter.sv
// aurora_tx_arbiter: packet-atomic 2:1 arbiter feeding Aurora TX (round-robin/forced/off, channel_up gated); ARB_WATCHDOG_EN adds stall abort.
// Latency: grant registers one cycle after an eligible request, the data path is combinational once granted, and there is one idle cycle between packets.
// Backpressure: owner tready = m_axis_tready & channel_up, the other source sees 0, and a stalled owner keeps the grant unless the watchdog aborts it.
module aurora_tx_arbiter #(
    parameter int DATA_W        = 32,
    parameter int STALL_TIMEOUT = 255
) (
    input  logic              user_clk,
    input  logic              sys_reset,
    input  logic              channel_up,
    input  logic [1:0]        ctrl_mode,
    input  logic              s0_axis_tvalid,
    input  logic [DATA_W-1:0] s0_axis_tdata,
    input  logic              s0_axis_tlast,
    output logic              s0_axis_tready,
    input  logic              s1_axis_tvalid,
    input  logic [DATA_W-1:0] s1_axis_tdata,
    input  logic              s1_axis_tlast,
    output logic              s1_axis_tready,
    output logic              m_axis_tvalid,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic [1:0]        grant,
    output logic [15:0]       stat_pkts_s0,
    output logic [15:0]       stat_pkts_s1,
    output logic              stat_abort
);

`ifdef ARB_WATCHDOG_EN
    typedef enum logic [2:0] {IDLE, OWN0, OWN1, ABORT, DRAIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
`endif

    state_t      state;
    logic [1:0]  grant_q;
    logic        last_q;
    logic [15:0] pkts_s0_q;
    logic [15:0] pkts_s1_q;

    logic own_src;
    logic own_vld;
    logic own_last;
    logic own_hs;
    logic req0;
    logic req1;

    // Owner identity lives in grant_q and stays valid through ABORT/DRAIN.
    assign own_src  = grant_q[1];
    assign own_vld  = own_src ? s1_axis_tvalid : s0_axis_tvalid;
    assign own_last = own_src ? s1_axis_tlast  : s0_axis_tlast;
    assign own_hs   = ((state == OWN0) || (state == OWN1)) && own_vld && m_axis_tready && channel_up;

    assign req0 = channel_up && s0_axis_tvalid && ((ctrl_mode == 2'b00) || (ctrl_mode == 2'b01));
    assign req1 = channel_up && s1_axis_tvalid && ((ctrl_mode == 2'b00) || (ctrl_mode == 2'b10));

`ifdef ARB_WATCHDOG_EN
    localparam int STALL_W = (STALL_TIMEOUT < 2) ? 1 : $clog2(STALL_TIMEOUT + 1);
    logic [STALL_W-1:0] stall_q;
    logic               first_q;
    logic               abort_q;
    assign stat_abort = abort_q;
`else
    logic unused_timeout;
    assign unused_timeout = (STALL_TIMEOUT != 0);
    assign stat_abort     = 1'b0;
`endif

    assign grant        = grant_q;
    assign stat_pkts_s0 = pkts_s0_q;
    assign stat_pkts_s1 = pkts_s1_q;

    always_comb begin
        m_axis_tvalid  = 1'b0;
        m_axis_tdata   = '0;
        m_axis_tlast   = 1'b0;
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        case (state)
            OWN0: begin
                m_axis_tvalid  = s0_axis_tvalid && channel_up;
                m_axis_tdata   = s0_axis_tdata;
                m_axis_tlast   = s0_axis_tlast;
                s0_axis_tready = m_axis_tready && channel_up;
            end
            OWN1: begin
                m_axis_tvalid  = s1_axis_tvalid && channel_up;
                m_axis_tdata   = s1_axis_tdata;
                m_axis_tlast   = s1_axis_tlast;
                s1_axis_tready = m_axis_tready && channel_up;
            end
`ifdef ARB_WATCHDOG_EN
            // Zero-data tlast beat closes the Aurora frame of the stalled packet.
            ABORT: begin
                m_axis_tvalid = channel_up;
                m_axis_tlast  = 1'b1;
            end
            DRAIN: begin
                s0_axis_tready = channel_up && !own_src;
                s1_axis_tready = channel_up && own_src;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge user_clk or posedge sys_reset) begin
        if (sys_reset) begin
            state     <= IDLE;
            grant_q   <= 2'b00;
            last_q    <= 1'b1;
            pkts_s0_q <= 16'd0;
            pkts_s1_q <= 16'd0;
`ifdef ARB_WATCHDOG_EN
            stall_q   <= '0;
            first_q   <= 1'b0;
            abort_q   <= 1'b0;
`endif
        end else begin
`ifdef ARB_WATCHDOG_EN
            abort_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
`ifdef ARB_WATCHDOG_EN
                    stall_q <= '0;
                    first_q <= 1'b0;
`endif
                    // On a tie, last_q = 1 means source 1 went last, so source 0 wins.
                    if (req0 && (!req1 || last_q)) begin
                        state   <= OWN0;
                        grant_q <= 2'b01;
                    end else if (req1) begin
                        state   <= OWN1;
                        grant_q <= 2'b10;
                    end
                end
                OWN0, OWN1: begin
                    if (own_hs && own_last) begin
                        state   <= IDLE;
                        grant_q <= 2'b00;
                        last_q  <= own_src;
                        if (own_src) begin
                            if (pkts_s1_q != 16'hFFFF) pkts_s1_q <= pkts_s1_q + 16'd1;
                        end else begin
                            if (pkts_s0_q != 16'hFFFF) pkts_s0_q <= pkts_s0_q + 16'd1;
                        end
                    end
`ifdef ARB_WATCHDOG_EN
                    else if (own_hs) begin
                        stall_q <= '0;
                        first_q <= 1'b1;
                    end else if (channel_up && !own_vld && first_q) begin
                        stall_q <= stall_q + 1'b1;
                        if (stall_q == STALL_W'(STALL_TIMEOUT - 1)) begin
                            state   <= ABORT;
                            abort_q <= 1'b1;
                        end
                    end
`endif
                end
`ifdef ARB_WATCHDOG_EN
                ABORT: begin
                    if (channel_up && m_axis_tready) state <= DRAIN;
                end
                DRAIN: begin
                    if (channel_up && own_vld && own_last) begin
                        state   <= IDLE;
                        grant_q <= 2'b00;
                        last_q  <= own_src;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aurora_tx_arbiter.sv
// Directed bench for aurora_tx_arbiter: per-cycle vector table plus hand sequences for round-robin, saturation, reset and stall.
module tb_aurora_tx_arbiter;

    logic        user_clk = 1'b0;
    logic        sys_reset = 1'b1;
    logic        channel_up = 1'b0;
    logic [1:0]  ctrl_mode = 2'b00;
    logic        s0_axis_tvalid = 1'b0;
    logic [31:0] s0_axis_tdata = '0;
    logic        s0_axis_tlast = 1'b0;
    logic        s0_axis_tready;
    logic        s1_axis_tvalid = 1'b0;
    logic [31:0] s1_axis_tdata = '0;
    logic        s1_axis_tlast = 1'b0;
    logic        s1_axis_tready;
    logic        m_axis_tvalid;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tready = 1'b1;
    logic [1:0]  grant;
    logic [15:0] stat_pkts_s0;
    logic [15:0] stat_pkts_s1;
    logic        stat_abort;

    int errors = 0;
    int checks = 0;

    aurora_tx_arbiter #(.DATA_W(32), .STALL_TIMEOUT(8)) dut (
        .user_clk(user_clk), .sys_reset(sys_reset), .channel_up(channel_up), .ctrl_mode(ctrl_mode),
        .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tdata(s0_axis_tdata), .s0_axis_tlast(s0_axis_tlast),
        .s0_axis_tready(s0_axis_tready),
        .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tdata(s1_axis_tdata), .s1_axis_tlast(s1_axis_tlast),
        .s1_axis_tready(s1_axis_tready),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .grant(grant), .stat_pkts_s0(stat_pkts_s0), .stat_pkts_s1(stat_pkts_s1), .stat_abort(stat_abort)
    );

    always #5 user_clk = ~user_clk;

    typedef struct {
        logic [1:0]  mode;
        logic        cu, v0, l0, v1, l1, mr;
        logic [31:0] d0, d1;
        logic [1:0]  g;
        logic        mv, ml, r0, r1;
        logic [31:0] md;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int mode, int cu, int v0, int d0, int l0, int v1, int d1, int l1, int mr,
                                int g, int mv, int md, int ml, int r0, int r1);
        vec_t v;
        v.mode = 2'(mode); v.cu = 1'(cu); v.v0 = 1'(v0); v.d0 = 32'(d0); v.l0 = 1'(l0);
        v.v1 = 1'(v1); v.d1 = 32'(d1); v.l1 = 1'(l1); v.mr = 1'(mr);
        v.g = 2'(g); v.mv = 1'(mv); v.md = 32'(md); v.ml = 1'(ml); v.r0 = 1'(r0); v.r1 = 1'(r1);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_cycle();
        @(posedge user_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_reset = 1'b1;
        s0_axis_tvalid = 1'b0; s1_axis_tvalid = 1'b0;
        s0_axis_tlast = 1'b0;  s1_axis_tlast = 1'b0;
        channel_up = 1'b1; ctrl_mode = 2'b00; m_axis_tready = 1'b1;
        repeat (2) @(posedge user_clk);
        #1 sys_reset = 1'b0;
    endtask

    task automatic send1_s0(input logic [31:0] d);
        bit ok;
        ok = 0;
        s0_axis_tvalid = 1'b1; s0_axis_tdata = d; s0_axis_tlast = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge user_clk);
            if (s0_axis_tready) begin
                ok = 1;
                break;
            end
        end
        drive_cycle();
        s0_axis_tvalid = 1'b0; s0_axis_tlast = 1'b0;
        chk("send1_s0_handshake", 32'(ok), 32'd1);
    endtask

    int rr_p0, rr_b0, rr_p1, rr_b1, rr_beats, rr_bubbles, stall_k;
    logic [31:0] rr_exp_d;
    logic [1:0]  rr_exp_g;
    bit stall_lost, stall_pulse;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state, held across one clock edge.
        @(negedge user_clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_mvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_tready0", 32'(s0_axis_tready), 32'd0);
        chk("rst_tready1", 32'(s1_axis_tready), 32'd0);
        chk("rst_pkts_s0", 32'(stat_pkts_s0), 32'd0);
        chk("rst_pkts_s1", 32'(stat_pkts_s1), 32'd0);
        chk("rst_abort", 32'(stat_abort), 32'd0);
        do_reset();
        channel_up = 1'b0;

        // mode,cu,v0,d0,l0,v1,d1,l1,mr | grant,mv,md,ml,r0,r1
        for (int i = 0; i < 2; i++) tbl.push_back(mk(0,0,1,'h11,0,1,'h22,0,1, 0,0,0,0,0,0));
        tbl.push_back(mk(1,1,1,'h5,0,1,'hAA,0,1, 0,0,0,0,0,0));
        tbl.push_back(mk(1,1,1,'h5,0,1,'hAA,0,1, 1,1,'h5,0,1,0));
        tbl.push_back(mk(1,1,1,'h3,1,1,'hAA,0,1, 1,1,'h3,1,1,0));
        for (int i = 0; i < 2; i++) tbl.push_back(mk(1,1,0,0,0,1,'hAA,0,1, 0,0,0,0,0,0));
        tbl.push_back(mk(2,1,1,'h77,1,1,'hD0,1,1, 0,0,0,0,0,0));
        tbl.push_back(mk(2,1,1,'h77,1,1,'hD0,1,0, 2,1,'hD0,1,0,0));
        tbl.push_back(mk(2,1,1,'h77,1,1,'hD0,1,1, 2,1,'hD0,1,0,1));
        for (int i = 0; i < 2; i++) tbl.push_back(mk(2,1,1,'h77,1,0,0,0,1, 0,0,0,0,0,0));
        tbl.push_back(mk(1,1,1,'hA0,0,0,0,0,1, 0,0,0,0,0,0));
        tbl.push_back(mk(1,1,1,'hA0,0,0,0,0,1, 1,1,'hA0,0,1,0));
        tbl.push_back(mk(1,1,1,'hA1,0,0,0,0,1, 1,1,'hA1,0,1,0));
        for (int i = 0; i < 10; i++) tbl.push_back(mk(1,0,1,'hA2,0,0,0,0,1, 1,0,0,0,0,0));
        tbl.push_back(mk(1,1,1,'hA2,0,0,0,0,1, 1,1,'hA2,0,1,0));
        tbl.push_back(mk(1,1,1,'hA3,1,0,0,0,1, 1,1,'hA3,1,1,0));
        tbl.push_back(mk(1,1,0,0,0,0,0,0,1, 0,0,0,0,0,0));
        tbl.push_back(mk(0,1,1,'hB0,0,0,0,0,1, 0,0,0,0,0,0));
        tbl.push_back(mk(3,1,1,'hB0,0,0,0,0,1, 1,1,'hB0,0,1,0));
        tbl.push_back(mk(3,1,1,'hB1,0,0,0,0,1, 1,1,'hB1,0,1,0));
        tbl.push_back(mk(3,1,1,'hB2,1,0,0,0,1, 1,1,'hB2,1,1,0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(3,1,1,'hC0,0,1,'hC1,0,1, 0,0,0,0,0,0));
        tbl.push_back(mk(0,1,1,'hE0,1,1,'hF0,1,1, 0,0,0,0,0,0));
        tbl.push_back(mk(0,1,1,'hE0,1,1,'hF0,1,1, 2,1,'hF0,1,0,1));
        tbl.push_back(mk(0,1,1,'hE0,1,1,'hF0,1,1, 0,0,0,0,0,0));
        tbl.push_back(mk(0,1,1,'hE0,1,1,'hF0,1,1, 1,1,'hE0,1,1,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,1, 0,0,0,0,0,0));

        foreach (tbl[i]) begin
            drive_cycle();
            ctrl_mode = tbl[i].mode; channel_up = tbl[i].cu; m_axis_tready = tbl[i].mr;
            s0_axis_tvalid = tbl[i].v0; s0_axis_tdata = tbl[i].d0; s0_axis_tlast = tbl[i].l0;
            s1_axis_tvalid = tbl[i].v1; s1_axis_tdata = tbl[i].d1; s1_axis_tlast = tbl[i].l1;
            @(negedge user_clk);
            chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(tbl[i].g));
            chk($sformatf("vec%0d_mvalid", i), 32'(m_axis_tvalid), 32'(tbl[i].mv));
            chk($sformatf("vec%0d_tready0", i), 32'(s0_axis_tready), 32'(tbl[i].r0));
            chk($sformatf("vec%0d_tready1", i), 32'(s1_axis_tready), 32'(tbl[i].r1));
            if (tbl[i].mv) begin
                chk($sformatf("vec%0d_mdata", i), m_axis_tdata, tbl[i].md);
                chk($sformatf("vec%0d_mlast", i), 32'(m_axis_tlast), 32'(tbl[i].ml));
            end
        end
        drive_cycle();
        chk("tbl_pkts_s0", 32'(stat_pkts_s0), 32'd4);
        chk("tbl_pkts_s1", 32'(stat_pkts_s1), 32'd2);

        // Round-robin with both sources streaming 3-beat packets back to back.
        do_reset();
        rr_p0 = 0; rr_b0 = 0; rr_p1 = 0; rr_b1 = 0; rr_beats = 0; rr_bubbles = 0;
        for (int cyc = 0; cyc < 60 && rr_beats < 12; cyc++) begin
            drive_cycle();
            s0_axis_tvalid = 1'b1; s0_axis_tdata = 32'(rr_p0 * 16 + rr_b0); s0_axis_tlast = (rr_b0 == 2);
            s1_axis_tvalid = 1'b1; s1_axis_tdata = 32'(256 + rr_p1 * 16 + rr_b1); s1_axis_tlast = (rr_b1 == 2);
            @(negedge user_clk);
            if (m_axis_tvalid && m_axis_tready) begin
                rr_exp_d = ((rr_beats / 3) % 2 == 1) ? 32'(256 + (rr_beats / 6) * 16 + rr_beats % 3)
                                                     : 32'((rr_beats / 6) * 16 + rr_beats % 3);
                rr_exp_g = ((rr_beats / 3) % 2 == 1) ? 2'b10 : 2'b01;
                chk($sformatf("rr%0d_data", rr_beats), m_axis_tdata, rr_exp_d);
                chk($sformatf("rr%0d_grant", rr_beats), 32'(grant), 32'(rr_exp_g));
                chk($sformatf("rr%0d_last", rr_beats), 32'(m_axis_tlast), 32'(rr_beats % 3 == 2));
                rr_beats++;
            end else if (rr_beats > 0) begin
                rr_bubbles++;
            end
            if (s0_axis_tvalid && s0_axis_tready) begin
                if (rr_b0 == 2) begin rr_b0 = 0; rr_p0++; end else rr_b0++;
            end
            if (s1_axis_tvalid && s1_axis_tready) begin
                if (rr_b1 == 2) begin rr_b1 = 0; rr_p1++; end else rr_b1++;
            end
        end
        drive_cycle();
        s0_axis_tvalid = 1'b0; s1_axis_tvalid = 1'b0;
        chk("rr_beat_count", 32'(rr_beats), 32'd12);
        chk("rr_bubbles", 32'(rr_bubbles), 32'd3);
        repeat (2) drive_cycle();
        chk("rr_pkts_s0", 32'(stat_pkts_s0), 32'd2);
        chk("rr_pkts_s1", 32'(stat_pkts_s1), 32'd2);
        chk("rr_idle_grant", 32'(grant), 32'd0);

        // Saturation from a preloaded count.
        ctrl_mode = 2'b01;
        @(negedge user_clk);
        force dut.pkts_s0_q = 16'hFFFE;
        #1 release dut.pkts_s0_q;
        drive_cycle();
        chk("sat_preload", 32'(stat_pkts_s0), 32'h0000FFFE);
        send1_s0(32'h1);
        chk("sat_first", 32'(stat_pkts_s0), 32'h0000FFFF);
        send1_s0(32'h2);
        send1_s0(32'h3);
        chk("sat_hold", 32'(stat_pkts_s0), 32'h0000FFFF);

        // Reset asserted mid-packet clears everything at once.
        s0_axis_tvalid = 1'b1; s0_axis_tdata = 32'h9; s0_axis_tlast = 1'b0;
        repeat (2) drive_cycle();
        @(negedge user_clk);
        chk("midrst_pre_grant", 32'(grant), 32'd1);
        #1 sys_reset = 1'b1;
        #1;
        chk("midrst_grant", 32'(grant), 32'd0);
        chk("midrst_mvalid", 32'(m_axis_tvalid), 32'd0);
        chk("midrst_tready0", 32'(s0_axis_tready), 32'd0);
        chk("midrst_pkts_s0", 32'(stat_pkts_s0), 32'd0);
        do_reset();

        // Mid-packet stall of source 0 while source 1 waits.
        s0_axis_tvalid = 1'b1; s0_axis_tdata = 32'h51; s0_axis_tlast = 1'b0;
        s1_axis_tvalid = 1'b1; s1_axis_tdata = 32'h61; s1_axis_tlast = 1'b1;
        @(negedge user_clk);
        chk("stall_idle_grant", 32'(grant), 32'd0);
        drive_cycle();
        @(negedge user_clk);
        chk("stall_first_beat", 32'(m_axis_tvalid && s0_axis_tready), 32'd1);
`ifdef ARB_WATCHDOG_EN
        stall_k = 0;
        for (int k = 1; k <= 20; k++) begin
            drive_cycle();
            s0_axis_tvalid = 1'b0;
            @(negedge user_clk);
            if (stat_abort) begin
                stall_k = k;
                break;
            end
        end
        chk("wd_abort_cycle", 32'(stall_k), 32'd9);
        chk("wd_abort_mvalid", 32'(m_axis_tvalid), 32'd1);
        chk("wd_abort_mdata", m_axis_tdata, 32'd0);
        chk("wd_abort_mlast", 32'(m_axis_tlast), 32'd1);
        chk("wd_abort_tready0", 32'(s0_axis_tready), 32'd0);
        drive_cycle();
        s0_axis_tvalid = 1'b1; s0_axis_tdata = 32'h52; s0_axis_tlast = 1'b0;
        @(negedge user_clk);
        chk("wd_drain_pulse", 32'(stat_abort), 32'd0);
        chk("wd_drain_mvalid", 32'(m_axis_tvalid), 32'd0);
        chk("wd_drain_tready0", 32'(s0_axis_tready), 32'd1);
        drive_cycle();
        s0_axis_tdata = 32'h53; s0_axis_tlast = 1'b1;
        @(negedge user_clk);
        chk("wd_drain_last_mvalid", 32'(m_axis_tvalid), 32'd0);
        drive_cycle();
        s0_axis_tdata = 32'h54; s0_axis_tlast = 1'b0;
        @(negedge user_clk);
        chk("wd_after_idle", 32'(grant), 32'd0);
        drive_cycle();
        @(negedge user_clk);
        chk("wd_next_grant", 32'(grant), 32'd2);
        chk("wd_next_data", m_axis_tdata, 32'h61);
        chk("wd_pkts_s0", 32'(stat_pkts_s0), 32'd0);
`else
        stall_lost = 0; stall_pulse = 0;
        for (int k = 1; k <= 20; k++) begin
            drive_cycle();
            s0_axis_tvalid = 1'b0;
            @(negedge user_clk);
            if (grant != 2'b01) stall_lost = 1;
            if (stat_abort) stall_pulse = 1;
        end
        chk("stall_grant_held", 32'(stall_lost), 32'd0);
        chk("stall_no_abort", 32'(stall_pulse), 32'd0);
        drive_cycle();
        s0_axis_tvalid = 1'b1; s0_axis_tdata = 32'h52; s0_axis_tlast = 1'b1;
        @(negedge user_clk);
        chk("stall_resume_data", m_axis_tdata, 32'h52);
        drive_cycle();
        s0_axis_tvalid = 1'b0;
        chk("stall_pkts_s0", 32'(stat_pkts_s0), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aurora_tx_arbiter.md
Name: aurora_tx_arbiter

Overview:
- Packet-atomic arbiter that shares the single Aurora 8b10b TX AXI-Stream slave between two packet sources: source 0 is the RX loopback FIFO and source 1 is the pre sequencer output.
- Replaces the static loopback mux in front of Aurora TX. Adds round-robin, forced or disabled source selection, gating on channel_up, and per-source packet counters for the future register interface.
- Sits in the user_clk domain between the stream sources and the Aurora core.

Parameters:
- DATA_W, 32, tdata width of all streams.
- STALL_TIMEOUT, 255, mid-packet source-stall limit in cycles. Used only with ARB_WATCHDOG_EN.

Ports:
- user_clk  in  1  Aurora user clock; all logic is on its rising edge.
- sys_reset  in  1  asynchronous, active-high reset. It is asynchronous on assertion and synchronously released to user_clk upstream.
- channel_up  in  1  Aurora channel status; beats move only while it is high.
- ctrl_mode  in  2  00 = round-robin, 01 = source 0 only, 10 = source 1 only, 11 = no new grants.
- s0_axis_tvalid / s0_axis_tdata / s0_axis_tlast  in  1/DATA_W/1  loopback source.
- s0_axis_tready  out  1
- s1_axis_tvalid / s1_axis_tdata / s1_axis_tlast  in  1/DATA_W/1  sequencer source.
- s1_axis_tready  out  1
- m_axis_tvalid / m_axis_tdata / m_axis_tlast  out  1/DATA_W/1  to Aurora s_axi_tx.
- m_axis_tready  in  1  from Aurora.
- grant  out  2  one-hot current owner: bit0 = source 0, bit1 = source 1; 00 when idle.
- stat_pkts_s0 / stat_pkts_s1  out  16 each  completed-packet counters, saturating.
- stat_abort  out  1  one-cycle pulse when the watchdog fires; tied 0 without the macro.

Behaviour:
- Reset values:
  - state IDLE, grant 00, last-served pointer = source 1 (so source 0 wins the first round-robin tie).
  - both counters 0, stat_abort 0, m_axis_tvalid 0, both treadys 0.
- FSM states: IDLE, OWN0, OWN1, plus ABORT and DRAIN when the watchdog is compiled in.
- IDLE:
  - Eligible request = sX_axis_tvalid AND ctrl_mode permits source X AND channel_up.
  - Mode 00: if both sources are eligible, grant the one not last served; otherwise grant the single eligible source.
  - Mode 01 or 10: grant only the forced source.
  - Mode 11: no grant.
  - Grant is registered, so a request seen at edge N gives grant at N+1. The first beat can transfer in the cycle after that edge.
- OWNx datapath (combinational from the registered grant):
  - m_axis_tdata = sX_axis_tdata, m_axis_tlast = sX_axis_tlast.
  - m_axis_tvalid = sX_axis_tvalid & channel_up.
  - sX_axis_tready = m_axis_tready & channel_up.
  - The non-granted source's tready is 0.
- OWNx exit:
  - A handshake with tlast = 1 moves the FSM to IDLE, updates last-served to X, and increments stat_pkts_sX. The counter saturates at 0xFFFF.
  - There is exactly one bubble cycle between packets.
- Changes in ctrl_mode take effect only in IDLE; an in-flight packet always completes.
- channel_up falling mid-packet: hold the grant and force all valids and readies to 0. Resume the same packet when channel_up returns. No beat is lost or duplicated.
- Packet counters increment only on a tlast handshake, never on an aborted packet.
- Asserting sys_reset mid-packet returns everything to reset values immediately. Source-side cleanup is the sources' responsibility, since they share the same reset.

Optional Feature:
- Macro: ARB_WATCHDOG_EN.
- With the macro, in OWNx:
  - A stall counter increments each cycle that channel_up = 1 and sX_axis_tvalid = 0 after the first beat of the packet has been accepted. Any accepted beat clears the counter.
  - When the counter reaches STALL_TIMEOUT, the FSM enters ABORT and pulses stat_abort.
  - ABORT drives m_axis_tvalid = 1, tdata = 0, tlast = 1 until it is accepted, which closes the Aurora frame. Source treadys are 0 during ABORT.
  - DRAIN then holds sX_axis_tready = 1 and m_axis_tvalid = 0, discarding beats until a source tlast handshake, then returns to IDLE.
  - Aborted packets do not increment the counters, but last-served is still updated.
- Without the macro: no stall counter, the ABORT and DRAIN states are absent, a stalled owner holds the grant indefinitely, and stat_abort is 0.

Test Plan:
- Mode 00, both sources present 3-beat packets continuously, m_axis_tready = 1 → grants alternate 01, 10, 01, …; order is s0, s1, s0; one bubble between packets; after 4 packets each counter reads 2.
- Mode 01, s1 valid the whole time and s0 sends one 2-beat packet → only s0 data (e.g. 0x5, then 0x3 with tlast) appears; s1_axis_tready is never 1; stat_pkts_s1 = 0.
- channel_up dropped for 10 cycles after beat 2 of a 4-beat packet → no handshakes during the drop; beats 3 and 4 follow afterwards unchanged; grant stays constant.
- ctrl_mode switched to 11 during beat 1 of 3 → the packet completes; no new grant while tvalids stay high; grant = 00.
- Counter preloaded near saturation (0xFFFE plus 3 more packets) → stat_pkts_s0 = 0xFFFF.
- ARB_WATCHDOG_EN with STALL_TIMEOUT = 8: s0 stops after beat 1 → stat_abort pulses after 8 stall cycles; a zero beat with tlast is emitted; the remaining s0 beats up to its tlast are discarded; stat_pkts_s0 is unchanged; s1 is granted next.
